// File: rtl/mac2_ctrl.sv
// mac2_ctrl: computes y = a*b + c*d by running two back-to-back multiplies
// through one shared start/busy shift-add multiplier and accumulating them.
// The first product goes into an accumulator. The final sum is registered
// on y_bo when the second multiply completes. If the multiplier never
// raises busy after a start pulse, err_o is set and the operation is dropped.

module mac2_ctrl #(
  parameter int W           = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [W-1:0]     a_bi,
  input  logic [W-1:0]     b_bi,
  input  logic [W-1:0]     c_bi,
  input  logic [W-1:0]     d_bi,
  input  logic             start_i,
  output logic             busy_o,
  output logic [2*W:0]     y_bo,
  output logic             err_o,
  output logic [W-1:0]     m_a_bo,
  output logic [W-1:0]     m_b_bo,
  output logic             m_start_o,
  input  logic             m_busy_i,
  input  logic [2*W-1:0]   m_y_bi
);

  // The counter must be able to hold ACK_TIMEOUT itself.
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    ACK1   = 3'd2,
    RUN1   = 3'd3,
    ISSUE2 = 3'd4,
    ACK2   = 3'd5,
    RUN2   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    c_q, c_d;
  logic [W-1:0]    d_q, d_d;
  logic [W-1:0]    m_a_q, m_a_d;
  logic [W-1:0]    m_b_q, m_b_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W:0]    y_q, y_d;
  logic            err_q, err_d;
  logic [CW-1:0]   ctr_q, ctr_d;
  logic [CW-1:0]   ctr_inc;
  logic            ack_expired;

  // The counter value after this cycle's wait, and whether it hits the limit.
  assign ctr_inc     = ctr_q + CW'(1);
  assign ack_expired = (ctr_inc == CW'(ACK_TIMEOUT));

  // The Moore outputs decode from the state register. The data outputs come straight from flops.
  assign busy_o    = (state_q != IDLE);
  assign m_start_o = (state_q == ISSUE1) || (state_q == ISSUE2);
  assign m_a_bo    = m_a_q;
  assign m_b_bo    = m_b_q;
  assign y_bo      = y_q;
  assign err_o     = err_q;

  // Next-state and datapath logic: each register holds by default and changes only on its step.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    m_a_d   = m_a_q;
    m_b_d   = m_b_q;
    acc_d   = acc_q;
    y_d     = y_q;
    err_d   = err_q;
    ctr_d   = ctr_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          m_a_d   = a_bi;
          m_b_d   = b_bi;
          c_d     = c_bi;
          d_d     = d_bi;
          err_d   = 1'b0;
          state_d = ISSUE1;
        end
      end

      ISSUE1: begin
        ctr_d   = '0;
        state_d = ACK1;
      end

      ACK1: begin
        if (m_busy_i) begin
          state_d = RUN1;
        end else begin
          ctr_d = ctr_inc;
          if (ack_expired) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      RUN1: begin
        if (!m_busy_i) begin
          acc_d   = m_y_bi;
          m_a_d   = c_q;
          m_b_d   = d_q;
          state_d = ISSUE2;
        end
      end

      ISSUE2: begin
        ctr_d   = '0;
        state_d = ACK2;
      end

      ACK2: begin
        if (m_busy_i) begin
          state_d = RUN2;
        end else begin
          ctr_d = ctr_inc;
          if (ack_expired) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      RUN2: begin
        if (!m_busy_i) begin
          y_d     = {1'b0, acc_q} + {1'b0, m_y_bi};
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The state and datapath registers. A synchronous reset drops any in-flight multiply.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      m_a_q   <= '0;
      m_b_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      m_a_q   <= m_a_d;
      m_b_q   <= m_b_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      err_q   <= err_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule
